// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU behind a single
// output register. The arbiter alternates grants when both requesters are
// valid, and returns each result one cycle after the request is accepted.
//
// state | meaning
// ------+--------------------------------------------------
// EMPTY | result register holds nothing, rsp_valid = 0
// FULL  | result register holds a result, rsp_valid = 1
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req0_op,
  input  logic [2:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_out,
  output logic         rsp_zero,
  output logic         rsp_id,
  output logic         rsp_illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic         r_last_grant;
  logic [W-1:0] r_rsp_out;
  logic         r_rsp_zero;
  logic         r_rsp_id;
  logic         r_rsp_illegal;

  logic         w_slot_free;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_grant;
  logic         w_grant_id;
  logic [2:0]   w_op;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_result;
  logic         w_zero;
  logic         w_illegal;

  // The slot can take a new result when empty or when the held one leaves now.
  assign w_slot_free = (r_state == EMPTY) || rsp_ready;

  // Round-robin grant; reset blocks every grant so nothing is accepted then.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst && w_slot_free) begin
      if (req0_valid && req1_valid) begin
        if (r_last_grant) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_grant    = w_grant0 | w_grant1;
  assign w_grant_id = w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Operand mux in front of the shared ALU.
  assign w_op = w_grant_id ? req1_op : req0_op;
  assign w_a  = w_grant_id ? req1_a  : req0_a;
  assign w_b  = w_grant_id ? req1_b  : req0_b;

  // Shared ALU; unsupported op codes produce zero with the illegal flag.
  always_comb begin
    w_result  = '0;
    w_zero    = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_ADD: w_result = w_a + w_b;
      OP_SUB: begin
        w_result = w_a - w_b;
        w_zero   = (w_a == w_b);
      end
      OP_OR:  w_result = w_a | w_b;
      OP_AND: w_result = w_a & w_b;
      OP_SLT: w_result = {{(W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      default: w_illegal = 1'b1;
    endcase
  end

  // Next-state logic for the output slot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_grant) w_state_nxt = FULL;
      FULL:  if (rsp_ready && !w_grant) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result payload register; loads only on a grant, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_out     <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else if (w_grant) begin
      r_rsp_out     <= w_result;
      r_rsp_zero    <= w_zero;
      r_rsp_id      <= w_grant_id;
      r_rsp_illegal <= w_illegal;
    end
  end

  // Last-grant pointer; resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_last_grant <= w_grant_id;
    end
  end

  assign rsp_valid   = (r_state == FULL);
  assign rsp_out     = r_rsp_out;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_id      = r_rsp_id;
  assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_out;
  logic         rsp_zero, rsp_id, rsp_illegal;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_out   = '0;
  logic         m_zero  = 1'b0;
  logic         m_id    = 1'b0;
  logic         m_ill   = 1'b0;
  logic         m_last  = 1'b1;

  logic seen0, seen1;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
    .rsp_illegal(rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, zero, result} from the op-code table.
  function automatic logic [W+1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return {2'b00, W'((longint'(a) + longint'(b)) % (longint'(1) << W))};
      3'd1: return {1'b0, (a == b), W'((longint'(a) - longint'(b) + (longint'(1) << W)) % (longint'(1) << W))};
      3'd2: return {2'b00, a | b};
      3'd3: return {2'b00, a & b};
      3'd5: return {2'b00, W'(sa < sb ? 1 : 0)};
      default: return {1'b1, 1'b0, W'(0)};
    endcase
  endfunction

  // One clock: drive inputs, check combinational readies, clock, check outputs.
  task automatic cycle(input logic t_rst,
                       input logic t_v0, input logic [2:0] t_op0, input logic [W-1:0] t_a0, input logic [W-1:0] t_b0,
                       input logic t_v1, input logic [2:0] t_op1, input logic [W-1:0] t_a1, input logic [W-1:0] t_b1,
                       input logic t_rr);
    logic free, g0, g1;
    logic [W+1:0] r;
    rst = t_rst; rsp_ready = t_rr;
    req0_valid = t_v0; req0_op = t_op0; req0_a = t_a0; req0_b = t_b0;
    req1_valid = t_v1; req1_op = t_op1; req1_a = t_a1; req1_b = t_b1;
    #3;
    free = !m_valid || t_rr;
    g0 = 1'b0; g1 = 1'b0;
    if (!t_rst && free) begin
      if (t_v0 && t_v1) begin
        g0 = (m_last == 1'b1);
        g1 = (m_last == 1'b0);
      end else begin
        g0 = t_v0;
        g1 = t_v1;
      end
    end
    seen0 = req0_ready;
    seen1 = req1_ready;
    check("req0_ready", W'(req0_ready), W'(g0));
    check("req1_ready", W'(req1_ready), W'(g1));
    @(posedge clk);
    #1;
    if (t_rst) begin
      m_valid = 0; m_out = '0; m_zero = 0; m_id = 0; m_ill = 0; m_last = 1;
    end else if (g0 || g1) begin
      r = g1 ? ref_alu(t_op1, t_a1, t_b1) : ref_alu(t_op0, t_a0, t_b0);
      m_valid = 1; m_out = r[W-1:0]; m_zero = r[W]; m_ill = r[W+1];
      m_id = g1; m_last = g1;
    end else if (m_valid && t_rr) begin
      m_valid = 0;
    end
    check("rsp_valid", W'(rsp_valid), W'(m_valid));
    check("rsp_out", rsp_out, m_out);
    check("rsp_zero", W'(rsp_zero), W'(m_zero));
    check("rsp_id", W'(rsp_id), W'(m_id));
    check("rsp_illegal", W'(rsp_illegal), W'(m_ill));
  endtask

  task automatic idle(input logic t_rr);
    cycle(0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0, t_rr);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // reset
    cycle(1, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1);
    cycle(1, 1, 3'd0, 1, 2, 1, 3'd0, 3, 4, 1);
    check("reset_valid", W'(rsp_valid), 0);
    check("reset_out", rsp_out, 0);

    // single ADD from requester 0
    cycle(0, 1, 3'd0, 5, 3, 0, 3'd0, 0, 0, 1);
    check("add_ready0", W'(seen0), 1);
    check("add_out", rsp_out, 8);
    check("add_id", W'(rsp_id), 0);
    check("add_valid", W'(rsp_valid), 1);
    idle(1);

    // round-robin after reset
    cycle(1, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 3'd0, W'(i), 1, 1, 3'd2, W'(i), 16, 1);
      check("rr_grant0", W'(seen0), W'(i % 2 == 0));
      check("rr_rsp_id", W'(rsp_id), W'(i % 2));
    end
    idle(1);

    // SUB equal then SLT signed from requester 1
    cycle(0, 0, 3'd0, 0, 0, 1, 3'd1, 7, 7, 1);
    check("sub_out", rsp_out, 0);
    check("sub_zero", W'(rsp_zero), 1);
    cycle(0, 0, 3'd0, 0, 0, 1, 3'd5, 32'hFFFF_FFFF, 1, 1);
    check("slt_out", rsp_out, 1);
    check("slt_zero", W'(rsp_zero), 0);
    idle(1);

    // stall for 3 cycles, then drain and grant together
    cycle(0, 1, 3'd0, 10, 20, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 3'd1, W'(100 + i), 1, 0, 3'd0, 0, 0, 0);
      check("stall_ready0", W'(seen0), 0);
      check("stall_out", rsp_out, 30);
    end
    cycle(0, 1, 3'd3, 32'hF0F0, 32'hFF00, 0, 3'd0, 0, 0, 1);
    check("drain_grant", W'(seen0), 1);
    check("drain_out", rsp_out, 32'hF000);
    idle(1);

    // illegal op
    cycle(0, 1, 3'd6, 9, 9, 0, 3'd0, 0, 0, 1);
    check("ill_flag", W'(rsp_illegal), 1);
    check("ill_out", rsp_out, 0);
    check("ill_valid", W'(rsp_valid), 1);
    idle(1);

    // reset while FULL
    cycle(0, 0, 3'd0, 0, 0, 1, 3'd0, 4, 4, 0);
    cycle(1, 1, 3'd0, 1, 1, 1, 3'd0, 2, 2, 0);
    check("rstfull_ready", W'({seen0, seen1}), 0);
    check("rstfull_valid", W'(rsp_valid), 0);
    cycle(0, 1, 3'd0, 1, 1, 1, 3'd0, 2, 2, 1);
    check("rstfull_first", W'(seen0), 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      cycle(($urandom_range(0, 39) == 0),
            1'($urandom), 3'($urandom), ra, rb,
            1'($urandom), 3'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? rb : $urandom,
            1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter W, default 32, operand/result width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1  requester N has an operation pending.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W  operands for requester N.
REQ-008 SHALL have ports req0_op, req1_op  input  3  operation code for requester N.
REQ-009 SHALL have port rsp_valid  output  1  result register holds a result.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port rsp_out  output  W  registered result.
REQ-012 SHALL have port rsp_zero  output  1  registered zero flag.
REQ-013 SHALL have port rsp_id  output  1  requester index that owns the result.
REQ-014 SHALL have port rsp_illegal  output  1  the result came from an unsupported op code.

Function
REQ-015 SHALL share one combinational ALU between both requesters, with one output register and one-cycle latency: accept at edge N, rsp_valid=1 after edge N.
REQ-016 SHALL use op codes ADD=000 (a+b), SUB=001 (a-b), OR=010, AND=011, SLT=101 (signed two's-complement a<b, result zero-extended to W).
REQ-017 SHALL set zero=1 only for SUB with a==b; for every other op, zero SHALL be 0.
REQ-018 SHALL treat op codes 100, 110 and 111 as illegal: result 0, zero 0, illegal flag 1. An illegal op SHALL still be accepted and returned.
REQ-019 SHALL use ADD/SUB modulo 2^W and ignore overflow.
REQ-020 SHALL define the output slot as free when rsp_valid==0 or (rsp_valid && rsp_ready).
REQ-021 SHALL grant at most one requester per cycle, and only when the slot is free.
REQ-022 SHALL grant the single valid requester when only one requester is valid.
REQ-023 SHALL grant the requester other than last_grant when both are valid (round-robin).
REQ-024 SHALL set last_grant to the granted index on each grant.
REQ-025 SHALL drive reqN_ready=1 exactly when requester N is granted; reqN_ready is combinational from valids, last_grant and the slot-free condition.
REQ-026 SHALL, on a grant, load rsp_out, rsp_zero, rsp_illegal and rsp_id from the granted request and set rsp_valid=1.
REQ-027 SHALL clear rsp_valid when the slot drains with no grant; the other rsp_* outputs SHALL hold their values.
REQ-028 SHALL, when a drain and a grant happen in the same cycle, load the new result with no bubble, giving throughput of one op per cycle.
REQ-029 SHALL keep rsp_out, rsp_zero, rsp_illegal and rsp_id stable while rsp_valid && !rsp_ready.
REQ-030 SHALL let requesters change operands while reqN_ready=0; those changes SHALL have no effect.
REQ-031 SHALL use two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-032 SHALL transition EMPTY->FULL on a grant.
REQ-033 SHALL transition FULL->EMPTY on a drain without a grant.
REQ-034 SHALL stay FULL on a stall, or on a drain with a grant.

Reset
REQ-035 SHALL, while rst=1 at a clock edge, set rsp_valid=0, rsp_out=0, rsp_zero=0, rsp_id=0, rsp_illegal=0 and last_grant=1, so requester 0 wins the first contention.
REQ-036 SHALL force req0_ready=req1_ready=0 while rst=1.
REQ-037 SHALL discard any held result when reset is asserted mid-operation; no request SHALL be accepted in that cycle.

Verification
REQ-038 SHALL cover: req0 ADD 5,3, rsp_ready=1 -> req0_ready=1 at cycle N; at N+1 rsp_valid=1, rsp_out=8, rsp_id=0, rsp_zero=0.
REQ-039 SHALL cover: both valid for 4 cycles after reset, rsp_ready=1 -> grants alternate 0,1,0,1, and rsp_id follows the same sequence one cycle later.
REQ-040 SHALL cover: req1 SUB 7,7, then SLT 0xFFFFFFFF,1 -> rsp_out=0 with rsp_zero=1, then rsp_out=1 with rsp_zero=0.
REQ-041 SHALL cover: result held with rsp_ready=0 for 3 cycles while req0 is valid -> req0_ready=0 and rsp_* stable; rsp_ready=1 -> drain and new grant in the same cycle.
REQ-042 SHALL cover: op=110, a=9, b=9 -> rsp_out=0, rsp_zero=0, rsp_illegal=1, rsp_valid=1.
REQ-043 SHALL cover: rst=1 while FULL -> next cycle rsp_valid=0, both ready=0; after release, both valid -> req0 granted first.
